// File: rtl/addrgen_pkg.sv
// Shared constants for the multi-channel AXI address generator: burst encodings,
// the 4 KiB boundary and an index-width helper.
package addrgen_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam int BOUNDARY_4K_BYTES = 4096;
    localparam int BOUNDARY_4K_BITS  = 12;

    // Width of an index into n items; never zero so single-item vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; on advance the pointer moves to the slot after the granted one.
module round_robin_arbiter
    import addrgen_pkg::*;
#(
    parameter int CHANNELS = 2
) (
    input  logic                aclk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] request,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant
);

    localparam int PTR_W = idx_width(CHANNELS);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             found;

    function automatic logic [PTR_W-1:0] wrap_idx(input int i);
        return PTR_W'((i >= CHANNELS) ? i - CHANNELS : i);
    endfunction

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 0; off < CHANNELS; off++) begin
            if (!found && request[wrap_idx(int'(ptr) + off)]) begin
                grant[wrap_idx(int'(ptr) + off)] = 1'b1;
                grant_idx = wrap_idx(int'(ptr) + off);
                found     = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge aclk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == PTR_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/multi_channel_address_generator.sv
// Multi-channel AXI address generator: splits per-channel beat requests into
// INCR bursts on one shared AXI address channel. Define ADDRGEN_4K_SPLIT_EN to
// also cut bursts at 4 KiB boundaries.
module multi_channel_address_generator
    import addrgen_pkg::*;
#(
    parameter int ADDR_WIDTH               = 32,
    parameter int ID_WIDTH                 = 8,
    parameter int CHANNELS                 = 2,
    parameter int AxLEN_BEATS_PER_TRANSFER = 15,
    parameter int AxSIZE_BYTES_PER_BEAT    = 3,
    parameter int AxBURST                  = 1
) (
    input  logic                           aclk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            start,
    output logic [CHANNELS-1:0]            done,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] startAddr,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] dataSizeInBeats,
    output logic [ID_WIDTH-1:0]            axid,
    output logic [ADDR_WIDTH-1:0]          axaddr,
    output logic [7:0]                     axlen,
    output logic [2:0]                     axsize,
    output logic [1:0]                     axburst,
    output logic                           axlock,
    output logic [3:0]                     axcache,
    output logic [2:0]                     axprot,
    output logic                           axvalid,
    input  logic                           axready
);

    localparam int CH_W = idx_width(CHANNELS);
    localparam logic [ADDR_WIDTH-1:0] MAX_BEATS = ADDR_WIDTH'(AxLEN_BEATS_PER_TRANSFER + 1);

    logic [ADDR_WIDTH-1:0] addr_q [CHANNELS];
    logic [ADDR_WIDTH-1:0] rem_q  [CHANNELS];

    logic [CHANNELS-1:0]   request;
    logic [CHANNELS-1:0]   grant;
    logic [CH_W-1:0]       sel_ch;
    logic [CH_W-1:0]       out_ch;
    logic                  out_last;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] sel_rem;
    logic [ADDR_WIDTH-1:0] limit;
    logic [ADDR_WIDTH-1:0] beats;
    logic                  load;
    logic                  handshake;

    assign axsize  = 3'(AxSIZE_BYTES_PER_BEAT);
    assign axburst = 2'(AxBURST);
    assign axlock  = 1'b0;
    assign axcache = 4'b0000;
    assign axprot  = 3'b000;
    assign axid    = ID_WIDTH'(out_ch);

    always_comb begin
        request = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            request[i] = (rem_q[i] != '0);
        end
    end

    round_robin_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .aclk    (aclk),
        .reset   (reset),
        .request (request),
        .advance (load),
        .grant   (grant)
    );

    always_comb begin
        sel_ch = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_ch = CH_W'(i);
            end
        end
    end

    assign sel_addr = addr_q[sel_ch];
    assign sel_rem  = rem_q[sel_ch];

`ifdef ADDRGEN_4K_SPLIT_EN
    logic [BOUNDARY_4K_BITS:0] bytes_to_4k;
    logic [ADDR_WIDTH-1:0]     beats_to_4k;

    assign bytes_to_4k = (BOUNDARY_4K_BITS + 1)'(BOUNDARY_4K_BYTES)
                       - {1'b0, sel_addr[BOUNDARY_4K_BITS-1:0]};
    assign beats_to_4k = ADDR_WIDTH'(bytes_to_4k >> AxSIZE_BYTES_PER_BEAT);

    always_comb begin
        limit = MAX_BEATS;
        if (beats_to_4k < limit) begin
            limit = beats_to_4k;
        end
        // A beat-unaligned address inside the last beat before the boundary
        // still issues one beat so the channel keeps making progress.
        if (limit == '0) begin
            limit = ADDR_WIDTH'(1);
        end
    end
`else
    assign limit = MAX_BEATS;
`endif

    assign beats     = (sel_rem < limit) ? sel_rem : limit;
    assign handshake = axvalid && axready;
    assign load      = (!axvalid || axready) && (|request);

    // Output register: holds the burst until accepted, reloads on the same edge.
    always_ff @(posedge aclk) begin
        if (reset) begin
            axvalid  <= 1'b0;
            axaddr   <= '0;
            axlen    <= '0;
            out_ch   <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            axvalid  <= 1'b1;
            axaddr   <= sel_addr;
            axlen    <= 8'(beats - ADDR_WIDTH'(1));
            out_ch   <= sel_ch;
            out_last <= (sel_rem == beats);
        end else if (handshake) begin
            axvalid  <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                addr_q[i] <= '0;
                rem_q[i]  <= '0;
                done[i]   <= 1'b1;
            end else if (start[i] && done[i]
                         && (dataSizeInBeats[i*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                addr_q[i] <= startAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                rem_q[i]  <= dataSizeInBeats[i*ADDR_WIDTH +: ADDR_WIDTH];
                done[i]   <= 1'b0;
            end else begin
                if (load && grant[i]) begin
                    addr_q[i] <= sel_addr + (beats << AxSIZE_BYTES_PER_BEAT);
                    rem_q[i]  <= sel_rem - beats;
                end
                // done returns only once the channel's final burst is accepted.
                if (handshake && out_last && (out_ch == CH_W'(i))) begin
                    done[i] <= 1'b1;
                end
            end
        end
    end

endmodule
